alu_preg: RTL and testbench
===========================

ALU_PREG -- requirements
Module: alu_preg

Interface
REQ-001 SHALL have parameter PREG, default 1, meaning: 1 = P/CARRYOUT/flag outputs registered, 0 = combinational.
REQ-002 SHALL have parameter CTRLREG, default 1, meaning: 1 = XSEL/ZSEL/ALUMODE registered, 0 = direct.
REQ-003 SHALL have parameter SEL_PATTERN, default 0, meaning: 0 = compare against PATTERN, 1 = compare against C.
REQ-004 SHALL have parameter PATTERN, default 48'h0, meaning: static detect pattern.
REQ-005 SHALL have parameter MASK, default 48'h3FFF_FFFF_FFFF, meaning: 1 bits are ignored in detection.
REQ-006 SHALL have ports in this order:
- clk  in  1  clock, all state on rising edge.
- RSTP_n  in  1  asynchronous active-low reset for all state in this block.
- CEP  in  1  clock enable for P/CARRYOUT/flags.
- CECTRL  in  1  clock enable for control registers.
- XSEL  in  2  X mux: 0 zero, 1 M, 2 AB, 3 P.
- ZSEL  in  2  Z mux: 0 zero, 1 P, 2 C, 3 P arithmetic-shifted right 17.
- ALUMODE  in  2  0 Z+X+CIN, 1 Z-(X+CIN), 2 X+CIN-Z, 3 same as 0.
- CIN  in  1  carry in.
- M  in  48  sign-extended multiplier product.
- AB  in  48  concatenated A:B operand.
- C  in  48  output of the C register stage.
- P  out  48  result.
- CARRYOUT  out  1  bit 48 of the add, or not-borrow for subtract modes.
- PATTERNDETECT  out  1  masked match of P to pattern.
- PATTERNBDETECT  out  1  masked match of P to the bitwise complement of pattern.
- OVERFLOW  out  1  detect-high followed by no match.
- UNDERFLOW  out  1  detect-bar-high followed by no match.

Function
REQ-007 SHALL compute the ALU result in 49 bits with zero-extended operands.
- Mode 0: Z+X+CIN.
- Mode 1: Z-X-CIN.
- Mode 2: X+CIN-Z.
- P_next = result[47:0].
REQ-008 SHALL set CARRYOUT_next = result[48] in modes 0/3 and ~result[48] in modes 1/2, where 1 means no borrow.
REQ-009 SHALL compute pattern matches on P_next.
- PATTERNDETECT_next = AND over bits of ((P_next XNOR pat) OR MASK).
- PATTERNBDETECT_next = AND over bits of ((P_next XOR pat) OR MASK).
- pat = PATTERN if SEL_PATTERN=0, else C.
REQ-010 SHALL, with PREG=1, load P, CARRYOUT and both detect flags on a clk edge when CEP=1, and hold them when CEP=0; latency from operands to P is 1 cycle.
REQ-011 SHALL, with PREG=1, hold PD_past/PBD_past registers updated with the old detect flags whenever CEP=1.
- OVERFLOW = PD_past & ~PATTERNDETECT & ~PATTERNBDETECT.
- UNDERFLOW = PBD_past & ~PATTERNDETECT & ~PATTERNBDETECT.
REQ-012 SHALL, with PREG=0, drive outputs combinationally from *_next and tie OVERFLOW and UNDERFLOW to 0.
REQ-013 SHALL, with PREG=0, force any XSEL=3 or ZSEL∈{1,3} selection to zero, so no combinational loop exists.
REQ-014 SHALL, with CTRLREG=1, register XSEL/ZSEL/ALUMODE under CECTRL; control therefore precedes its data by one cycle.
REQ-015 SHALL, with CTRLREG=0, use XSEL/ZSEL/ALUMODE directly.
REQ-016 SHALL sign-extend the ZSEL=3 shift from P[47].
REQ-017 SHALL let wrap-around at 2^48 occur silently, reported only via CARRYOUT and OVERFLOW/UNDERFLOW.

Reset
REQ-018 SHALL, while RSTP_n=0, immediately clear P, CARRYOUT, both detect flags, both past flags and the control registers, giving OVERFLOW=UNDERFLOW=0.
REQ-019 SHALL give reset priority over CEP and CECTRL.
REQ-020 SHALL discard any in-flight accumulation on reset asserted mid-operation.
REQ-021 SHALL update normally on the first clk edge after deassertion.

Structure
REQ-022 SHALL take XSEL/ZSEL/ALUMODE encodings and the width constant 48 from shared package dsp_slice_pkg.
REQ-023 SHALL place the mask/compare logic in one sub-module, pat_detect, instantiated once and shared by both detect outputs.

Verification
REQ-024 Accumulate: XSEL=1, ZSEL=1, ALUMODE=0, M=5 for 4 cycles from reset -> P = 5, 10, 15, 20.
REQ-025 Carry: XSEL=2, AB=48'hFFFF_FFFF_FFFF, ZSEL=2, C=1 -> P=0, CARRYOUT=1; same operands with ALUMODE=1 -> P=2, CARRYOUT=0.
REQ-026 Overflow: SEL_PATTERN=0 with defaults; accumulate M=1 across P=48'h3FFF_FFFF_FFFF -> 48'h4000_0000_0000.
- PATTERNDETECT=1 on the earlier value.
- OVERFLOW=1 one cycle after the boundary crossing.
REQ-027 Hold/reset: CEP=0 with changing M -> P is unchanged; RSTP_n pulsed low between edges -> all outputs 0 with no clk edge.
REQ-028 PREG=0 with XSEL=3 -> treated as zero; result equals Z+CIN in the same cycle.

Source files
------------

// File: rtl/dsp_slice_pkg.sv
// -----------------------------------------------------------------------------
// dsp_slice_pkg
// Shared definitions for the DSP slice post-adder stage: datapath width,
// X/Z operand-select encodings, ALU mode encodings and a small helper that
// classifies the subtracting ALU modes.
// -----------------------------------------------------------------------------
package dsp_slice_pkg;

    // Datapath width of P, C, M and AB.
    localparam int unsigned DW = 32'd48;

    // Arithmetic right-shift distance used by the ZSEL "shifted P" operand.
    localparam int unsigned PSHIFT = 32'd17;

    typedef enum logic [1:0] {
        XSEL_ZERO = 2'd0,
        XSEL_M    = 2'd1,
        XSEL_AB   = 2'd2,
        XSEL_P    = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        ZSEL_ZERO   = 2'd0,
        ZSEL_P      = 2'd1,
        ZSEL_C      = 2'd2,
        ZSEL_PSHIFT = 2'd3
    } zsel_e;

    typedef enum logic [1:0] {
        ALU_ADD     = 2'd0,  // Z + X + CIN
        ALU_ZMX     = 2'd1,  // Z - (X + CIN)
        ALU_XMZ     = 2'd2,  // X + CIN - Z
        ALU_ADD_ALT = 2'd3   // alias of ALU_ADD
    } alumode_e;

    // Subtracting modes report carry-out as "no borrow", i.e. inverted bit 48.
    function automatic logic alu_is_sub(input alumode_e mode);
        return (mode == ALU_ZMX) || (mode == ALU_XMZ);
    endfunction

endpackage : dsp_slice_pkg

// File: rtl/pat_detect.sv
// -----------------------------------------------------------------------------
// pat_detect
// Masked pattern comparator shared by both detect outputs. A mask bit of 1
// removes that bit from the comparison.
//   p_i    : value under test
//   pat_i  : pattern to compare against
//   mask_i : ignore mask (1 = don't care)
//   pd_o   : p_i matches pat_i on every unmasked bit
//   pbd_o  : p_i matches ~pat_i on every unmasked bit
// -----------------------------------------------------------------------------
module pat_detect
    import dsp_slice_pkg::*;
(
    input  logic [DW-1:0] p_i,
    input  logic [DW-1:0] pat_i,
    input  logic [DW-1:0] mask_i,
    output logic          pd_o,
    output logic          pbd_o
);

    assign pd_o  = &((p_i ~^ pat_i) | mask_i);
    assign pbd_o = &((p_i ^  pat_i) | mask_i);

endmodule : pat_detect

// File: rtl/alu_preg.sv
// -----------------------------------------------------------------------------
// alu_preg
// Post-multiplier ALU of a DSP slice with optional output (P) and control
// registers, carry-out and masked pattern / overflow detection.
//   clk            : clock, all state on rising edge
//   RSTP_n         : asynchronous active-low reset for all state
//   CEP            : clock enable for P, CARRYOUT, detect and past flags
//   CECTRL         : clock enable for XSEL/ZSEL/ALUMODE registers
//   XSEL           : X operand select (zero / M / AB / P)
//   ZSEL           : Z operand select (zero / P / C / P>>>17)
//   ALUMODE        : Z+X+CIN, Z-(X+CIN), X+CIN-Z, Z+X+CIN
//   CIN            : carry in
//   M, AB, C       : 48-bit operands
//   P              : result
//   CARRYOUT       : carry (add) or not-borrow (subtract)
//   PATTERNDETECT  : masked match of P against the pattern
//   PATTERNBDETECT : masked match of P against the complemented pattern
//   OVERFLOW       : previous detect high, now neither detect matches
//   UNDERFLOW      : previous detect-bar high, now neither detect matches
// -----------------------------------------------------------------------------
module alu_preg
    import dsp_slice_pkg::*;
#(
    parameter int unsigned   PREG        = 32'd1,
    parameter int unsigned   CTRLREG     = 32'd1,
    parameter int unsigned   SEL_PATTERN = 32'd0,
    parameter logic [DW-1:0] PATTERN     = 48'h0,
    parameter logic [DW-1:0] MASK        = 48'h3FFF_FFFF_FFFF
)(
    input  logic          clk,
    input  logic          RSTP_n,
    input  logic          CEP,
    input  logic          CECTRL,
    input  logic [1:0]    XSEL,
    input  logic [1:0]    ZSEL,
    input  logic [1:0]    ALUMODE,
    input  logic          CIN,
    input  logic [DW-1:0] M,
    input  logic [DW-1:0] AB,
    input  logic [DW-1:0] C,
    output logic [DW-1:0] P,
    output logic          CARRYOUT,
    output logic          PATTERNDETECT,
    output logic          PATTERNBDETECT,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
);

    localparam bit USE_PREG    = (PREG != 32'd0);
    localparam bit USE_CTRLREG = (CTRLREG != 32'd0);
    localparam bit USE_C_PAT   = (SEL_PATTERN != 32'd0);

    // Control path
    xsel_e    xsel_q;
    zsel_e    zsel_q;
    alumode_e mode_q;
    xsel_e    xsel_s;
    zsel_e    zsel_s;
    alumode_e mode_s;

    // Datapath
    logic [DW-1:0] p_q;
    logic [DW-1:0] p_d;
    logic [DW-1:0] p_fb_s;
    logic [DW-1:0] p_shift_s;
    logic [DW-1:0] x_s;
    logic [DW-1:0] z_s;
    logic [DW-1:0] pat_s;
    logic [DW:0]   res_s;
    logic          co_q;
    logic          co_d;
    logic          pd_q;
    logic          pd_d;
    logic          pbd_q;
    logic          pbd_d;
    logic          pd_past_q;
    logic          pbd_past_q;

    // Control registers: loaded under CECTRL, so a control word applies to
    // the operands presented one cycle later.
    always_ff @(posedge clk or negedge RSTP_n) begin
        if (!RSTP_n) begin
            xsel_q <= XSEL_ZERO;
            zsel_q <= ZSEL_ZERO;
            mode_q <= ALU_ADD;
        end else if (CECTRL) begin
            xsel_q <= xsel_e'(XSEL);
            zsel_q <= zsel_e'(ZSEL);
            mode_q <= alumode_e'(ALUMODE);
        end
    end

    assign xsel_s = USE_CTRLREG ? xsel_q : xsel_e'(XSEL);
    assign zsel_s = USE_CTRLREG ? zsel_q : zsel_e'(ZSEL);
    assign mode_s = USE_CTRLREG ? mode_q : alumode_e'(ALUMODE);

    // Without a P register, feeding P back would close a combinational loop,
    // so every P-derived operand collapses to zero.
    assign p_fb_s    = USE_PREG ? p_q : '0;
    assign p_shift_s = $signed(p_fb_s) >>> PSHIFT;
    assign pat_s     = USE_C_PAT ? C : PATTERN;

    // X operand multiplexer.
    always_comb begin
        x_s = '0;
        case (xsel_s)
            XSEL_ZERO: x_s = '0;
            XSEL_M:    x_s = M;
            XSEL_AB:   x_s = AB;
            XSEL_P:    x_s = p_fb_s;
            default:   x_s = '0;
        endcase
    end

    // Z operand multiplexer.
    always_comb begin
        z_s = '0;
        case (zsel_s)
            ZSEL_ZERO:   z_s = '0;
            ZSEL_P:      z_s = p_fb_s;
            ZSEL_C:      z_s = C;
            ZSEL_PSHIFT: z_s = p_shift_s;
            default:     z_s = '0;
        endcase
    end

    // 49-bit ALU on zero-extended operands; bit 48 feeds CARRYOUT.
    always_comb begin
        res_s = '0;
        case (mode_s)
            ALU_ZMX:  res_s = {1'b0, z_s} - {1'b0, x_s} - {{DW{1'b0}}, CIN};
            ALU_XMZ:  res_s = {1'b0, x_s} + {{DW{1'b0}}, CIN} - {1'b0, z_s};
            ALU_ADD,
            ALU_ADD_ALT: res_s = {1'b0, z_s} + {1'b0, x_s} + {{DW{1'b0}}, CIN};
            default:  res_s = {1'b0, z_s} + {1'b0, x_s} + {{DW{1'b0}}, CIN};
        endcase
    end

    assign p_d  = res_s[DW-1:0];
    assign co_d = alu_is_sub(mode_s) ? ~res_s[DW] : res_s[DW];

    pat_detect u_pat_detect (
        .p_i    (p_d),
        .pat_i  (pat_s),
        .mask_i (MASK),
        .pd_o   (pd_d),
        .pbd_o  (pbd_d)
    );

    // Output register stage; past flags capture the detect flags being
    // replaced so a match-to-no-match transition can be seen.
    always_ff @(posedge clk or negedge RSTP_n) begin
        if (!RSTP_n) begin
            p_q        <= '0;
            co_q       <= 1'b0;
            pd_q       <= 1'b0;
            pbd_q      <= 1'b0;
            pd_past_q  <= 1'b0;
            pbd_past_q <= 1'b0;
        end else if (CEP) begin
            p_q        <= p_d;
            co_q       <= co_d;
            pd_q       <= pd_d;
            pbd_q      <= pbd_d;
            pd_past_q  <= pd_q;
            pbd_past_q <= pbd_q;
        end
    end

    assign P              = USE_PREG ? p_q   : p_d;
    assign CARRYOUT       = USE_PREG ? co_q  : co_d;
    assign PATTERNDETECT  = USE_PREG ? pd_q  : pd_d;
    assign PATTERNBDETECT = USE_PREG ? pbd_q : pbd_d;
    assign OVERFLOW       = USE_PREG ? (pd_past_q  & ~pd_q & ~pbd_q) : 1'b0;
    assign UNDERFLOW      = USE_PREG ? (pbd_past_q & ~pd_q & ~pbd_q) : 1'b0;

endmodule : alu_preg

// File: tb/tb_alu_preg.sv
// -----------------------------------------------------------------------------
// tb_alu_preg
// Self-checking bench: u_dut uses default parameters (registered P and
// control); u_comb uses PREG=0, CTRLREG=0, SEL_PATTERN=1. Both are compared
// every cycle against a behavioural model, plus directed scenarios.
// -----------------------------------------------------------------------------
module tb_alu_preg;

    localparam logic [47:0] MASK_R = 48'h3FFF_FFFF_FFFF;
    localparam logic [47:0] PAT_R  = 48'h0;

    logic        clk;
    logic        RSTP_n;
    logic        CEP;
    logic        CECTRL;
    logic [1:0]  XSEL;
    logic [1:0]  ZSEL;
    logic [1:0]  ALUMODE;
    logic        CIN;
    logic [47:0] M;
    logic [47:0] AB;
    logic [47:0] C;

    logic [47:0] P;
    logic        CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW;
    logic [47:0] P_c;
    logic        CARRYOUT_c, PATTERNDETECT_c, PATTERNBDETECT_c, OVERFLOW_c, UNDERFLOW_c;

    int n_vec = 0;
    int n_err = 0;

    // Model state of u_dut
    int          m_x, m_z, m_mode;
    logic [47:0] m_p;
    logic        m_co, m_pd, m_pbd, m_pdp, m_pbdp;

    alu_preg u_dut (
        .clk(clk), .RSTP_n(RSTP_n), .CEP(CEP), .CECTRL(CECTRL),
        .XSEL(XSEL), .ZSEL(ZSEL), .ALUMODE(ALUMODE), .CIN(CIN),
        .M(M), .AB(AB), .C(C),
        .P(P), .CARRYOUT(CARRYOUT), .PATTERNDETECT(PATTERNDETECT),
        .PATTERNBDETECT(PATTERNBDETECT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    alu_preg #(.PREG(32'd0), .CTRLREG(32'd0), .SEL_PATTERN(32'd1)) u_comb (
        .clk(clk), .RSTP_n(RSTP_n), .CEP(CEP), .CECTRL(CECTRL),
        .XSEL(XSEL), .ZSEL(ZSEL), .ALUMODE(ALUMODE), .CIN(CIN),
        .M(M), .AB(AB), .C(C),
        .P(P_c), .CARRYOUT(CARRYOUT_c), .PATTERNDETECT(PATTERNDETECT_c),
        .PATTERNBDETECT(PATTERNBDETECT_c), .OVERFLOW(OVERFLOW_c), .UNDERFLOW(UNDERFLOW_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU: selects operands by the documented meaning of each code,
    // then does the 49-bit arithmetic. preg=0 means P is not available.
    function automatic logic [48:0] alu_ref(input int xs, input int zs, input int md,
                                            input logic cin, input logic [47:0] p,
                                            input logic [47:0] m, input logic [47:0] ab,
                                            input logic [47:0] c, input bit preg);
        logic [47:0] x, z, ones, pf;
        logic [48:0] x9, z9, c9;
        ones = 48'hFFFF_FFFF_FFFF;
        pf   = preg ? p : 48'd0;
        case (xs)
            1:       x = m;
            2:       x = ab;
            3:       x = pf;
            default: x = 48'd0;
        endcase
        case (zs)
            1:       z = pf;
            2:       z = c;
            3:       z = (pf >> 17) | (pf[47] ? ~(ones >> 17) : 48'd0);
            default: z = 48'd0;
        endcase
        x9 = {1'b0, x};
        z9 = {1'b0, z};
        c9 = {48'd0, cin};
        case (md)
            1:       return z9 - x9 - c9;
            2:       return x9 + c9 - z9;
            default: return z9 + x9 + c9;
        endcase
    endfunction

    function automatic logic carry_ref(input int md, input logic [48:0] r);
        return (md == 1 || md == 2) ? ~r[48] : r[48];
    endfunction

    // Masked equality: only bits where MASK is 0 take part.
    function automatic logic det(input logic [47:0] p, input logic [47:0] pat);
        return ((p ^ pat) & ~MASK_R) == 48'd0;
    endfunction

    task automatic model_reset();
        m_x = 0; m_z = 0; m_mode = 0;
        m_p = 48'd0; m_co = 1'b0; m_pd = 1'b0; m_pbd = 1'b0;
        m_pdp = 1'b0; m_pbdp = 1'b0;
    endtask

    task automatic model_step();
        logic [48:0] r;
        if (CEP) begin
            r      = alu_ref(m_x, m_z, m_mode, CIN, m_p, M, AB, C, 1'b1);
            m_pdp  = m_pd;
            m_pbdp = m_pbd;
            m_p    = r[47:0];
            m_co   = carry_ref(m_mode, r);
            m_pd   = det(m_p, PAT_R);
            m_pbd  = det(m_p, ~PAT_R);
        end
        if (CECTRL) begin
            m_x = int'(XSEL); m_z = int'(ZSEL); m_mode = int'(ALUMODE);
        end
    endtask

    task automatic check_main();
        chk("P", 64'(P), 64'(m_p));
        chk("CARRYOUT", 64'(CARRYOUT), 64'(m_co));
        chk("PD", 64'(PATTERNDETECT), 64'(m_pd));
        chk("PBD", 64'(PATTERNBDETECT), 64'(m_pbd));
        chk("OVERFLOW", 64'(OVERFLOW), 64'(m_pdp & ~m_pd & ~m_pbd));
        chk("UNDERFLOW", 64'(UNDERFLOW), 64'(m_pbdp & ~m_pd & ~m_pbd));
    endtask

    task automatic check_comb();
        logic [48:0] r;
        r = alu_ref(int'(XSEL), int'(ZSEL), int'(ALUMODE), CIN, 48'd0, M, AB, C, 1'b0);
        chk("comb_P", 64'(P_c), 64'(r[47:0]));
        chk("comb_CO", 64'(CARRYOUT_c), 64'(carry_ref(int'(ALUMODE), r)));
        chk("comb_PD", 64'(PATTERNDETECT_c), 64'(det(r[47:0], C)));
        chk("comb_PBD", 64'(PATTERNBDETECT_c), 64'(det(r[47:0], ~C)));
        chk("comb_OVF_UNF", 64'({OVERFLOW_c, UNDERFLOW_c}), 64'd0);
    endtask

    // Entered between edges with inputs already driven; returns at negedge.
    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_main();
        @(negedge clk);
    endtask

    // Reset pulse entirely between clock edges; entered at a negedge.
    task automatic pulse_reset();
        #1 RSTP_n = 1'b0;
        #1;
        model_reset();
        chk("rst_P", 64'(P), 64'd0);
        chk("rst_flags", 64'({CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW}), 64'd0);
        #1 RSTP_n = 1'b1;
    endtask

    task automatic set_ops(input logic [1:0] xs, input logic [1:0] zs, input logic [1:0] md,
                           input logic cin, input logic [47:0] m, input logic [47:0] ab,
                           input logic [47:0] c);
        XSEL = xs; ZSEL = zs; ALUMODE = md; CIN = cin; M = m; AB = ab; C = c;
    endtask

    initial begin
        logic [47:0] held;
        RSTP_n = 1'b0; CEP = 1'b0; CECTRL = 1'b0;
        set_ops(2'd0, 2'd0, 2'd0, 1'b0, 48'd0, 48'd0, 48'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_P", 64'(P), 64'd0);
        chk("init_flags", 64'({CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW}), 64'd0);
        #1 RSTP_n = 1'b1;

        // Accumulate M=5: load control first, then four enabled edges.
        set_ops(2'd1, 2'd1, 2'd0, 1'b0, 48'd5, 48'd0, 48'd0);
        CECTRL = 1'b1;
        cycle();
        CEP = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("accumulate", 64'(P), 64'(5 * i));
        end

        // Carry and borrow with AB all ones, C = 1.
        set_ops(2'd2, 2'd2, 2'd0, 1'b0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd1);
        cycle(); cycle();
        chk("carry_P", 64'(P), 64'd0);
        chk("carry_CO", 64'(CARRYOUT), 64'd1);
        ALUMODE = 2'd1;
        cycle(); cycle();
        chk("borrow_P", 64'(P), 64'd2);
        chk("borrow_CO", 64'(CARRYOUT), 64'd0);

        // Overflow across the 3FFF_FFFF_FFFF -> 4000_0000_0000 boundary.
        pulse_reset();
        set_ops(2'd0, 2'd2, 2'd0, 1'b0, 48'd1, 48'd0, 48'h3FFF_FFFF_FFFE);
        cycle(); cycle();
        XSEL = 2'd1; ZSEL = 2'd1;
        cycle();
        cycle();
        chk("ovf_pre_P", 64'(P), 64'h3FFF_FFFF_FFFF);
        chk("ovf_pre_PD", 64'(PATTERNDETECT), 64'd1);
        chk("ovf_pre_OVF", 64'(OVERFLOW), 64'd0);
        cycle();
        chk("ovf_P", 64'(P), 64'h4000_0000_0000);
        chk("ovf_OVF", 64'(OVERFLOW), 64'd1);
        cycle();
        chk("ovf_after", 64'(OVERFLOW), 64'd0);

        // Hold with CEP low while M changes.
        CEP  = 1'b0;
        held = P;
        for (int i = 0; i < 4; i++) begin
            M = 48'($urandom());
            cycle();
            chk("hold_P", 64'(P), 64'(held));
        end
        pulse_reset();

        // Combinational instance: XSEL=3 is treated as zero.
        set_ops(2'd3, 2'd2, 2'd0, 1'b1, 48'h55, 48'h77, 48'h0000_1234_5678);
        cycle();
        chk("xsel3_comb", 64'(P_c), 64'h0000_1234_5679);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset();
            CEP    = ($urandom_range(0, 4) != 0);
            CECTRL = ($urandom_range(0, 3) != 0);
            XSEL    = 2'($urandom_range(0, 3));
            ZSEL    = 2'($urandom_range(0, 3));
            ALUMODE = 2'($urandom_range(0, 3));
            CIN     = 1'($urandom_range(0, 1));
            M  = ($urandom_range(0, 1) == 0) ? 48'($urandom_range(0, 15)) : 48'({$urandom(), $urandom()});
            AB = 48'({$urandom(), $urandom()});
            C  = ($urandom_range(0, 3) == 0) ? 48'hC000_0000_0000 | 48'($urandom()) : 48'({$urandom(), $urandom()});
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_preg
